// File: rtl/tdc_mhit_packer.sv
// Multi-hit TDC packer: arms a coarse window on a start edge, buffers up to MAX_HITS
// {coarse, fine, intensity} hits, then streams them out as one frame with a done pulse.
module tdc_mhit_packer #(
  parameter int unsigned COARSE_W = 12,
  parameter int unsigned PHASE_N  = 32,
  parameter int unsigned SPAD_N   = 16,
  parameter int unsigned MAX_HITS = 4,
  parameter int unsigned RANGE    = 4095
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [PHASE_N-1:0]                     DLL_Phase,
  input  logic                                   TDC_start,
  input  logic                                   TDC_trigger,
  input  logic                                   TDC_tgate,
  input  logic [SPAD_N-1:0]                      TDC_spaden,
  output logic [COARSE_W+$clog2(PHASE_N)-1:0]    TDC_Odata,
  output logic [$clog2(SPAD_N+1)-1:0]            TDC_Oint,
  output logic [$clog2(MAX_HITS+1)-1:0]          TDC_Onum,
  output logic                                   TDC_Olast,
  output logic                                   TDC_Ovalid,
  input  logic                                   TDC_Oready,
  output logic                                   TDC_Oovf,
  output logic                                   TDC_INT
);

  localparam int unsigned FINE_W = $clog2(PHASE_N);
  localparam int unsigned PCNT_W = FINE_W + 1;
  localparam int unsigned INT_W  = $clog2(SPAD_N + 1);
  localparam int unsigned NUM_W  = $clog2(MAX_HITS + 1);
  localparam int unsigned IDX_W  = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1;
  localparam int unsigned DATA_W = COARSE_W + FINE_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]          r_state;
  logic                r_start_d;
  logic                r_trig_d;
  logic [COARSE_W-1:0] r_coarse;
  logic [NUM_W-1:0]    r_count;
  logic                r_ovf;
  logic                r_grace;
  logic [NUM_W-1:0]    r_rd_idx;
  logic [DATA_W-1:0]   r_buf_data [MAX_HITS];
  logic [INT_W-1:0]    r_buf_int  [MAX_HITS];

  logic [PCNT_W-1:0]   w_phase_cnt;
  logic [INT_W-1:0]    w_spad_cnt;
  logic [DATA_W-1:0]   w_hit_data;
  logic                w_start_rise;
  logic                w_hit;
  logic                w_full;
  logic                w_store;
  logic                w_drop;
  logic                w_close;
  logic [NUM_W-1:0]    w_count_after;
  logic [NUM_W-1:0]    w_rd_inc;

  logic [1:0]          w_state_nxt;
  logic [COARSE_W-1:0] w_coarse_nxt;
  logic [NUM_W-1:0]    w_count_nxt;
  logic                w_ovf_nxt;
  logic                w_grace_nxt;
  logic [NUM_W-1:0]    w_rd_nxt;
  logic                w_wr_en;
  logic                w_valid_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [INT_W-1:0]    w_int_nxt;
  logic [NUM_W-1:0]    w_num_nxt;
  logic                w_last_nxt;
  logic                w_oovf_nxt;
  logic                w_irq_nxt;

  // Fine code is the thermometer depth, wrapping a fully-set vector to 0
  always_comb begin
    w_phase_cnt = '0;
    for (int i = 0; i < PHASE_N; i++) w_phase_cnt = w_phase_cnt + PCNT_W'(DLL_Phase[i]);
  end

  always_comb begin
    w_spad_cnt = '0;
    for (int i = 0; i < SPAD_N; i++) w_spad_cnt = w_spad_cnt + INT_W'(TDC_spaden[i]);
  end

  assign w_hit_data    = {r_coarse, FINE_W'(w_phase_cnt)};
  assign w_start_rise  = TDC_start & ~r_start_d;
  assign w_hit         = (r_state == S_ARMED) & TDC_trigger & ~r_trig_d & TDC_tgate;
  assign w_full        = (r_count == NUM_W'(MAX_HITS));
  assign w_store       = w_hit & ~w_full;
  assign w_drop        = w_hit & w_full;
  // A full buffer keeps the window open one grace cycle so a trailing hit is flagged as overflow
  assign w_close       = (r_coarse == COARSE_W'(RANGE)) | (r_grace & w_full);
  assign w_count_after = r_count + NUM_W'(w_store);
  assign w_rd_inc      = r_rd_idx + NUM_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_coarse_nxt = r_coarse;
    w_count_nxt  = r_count;
    w_ovf_nxt    = r_ovf;
    w_grace_nxt  = 1'b0;
    w_rd_nxt     = r_rd_idx;
    w_wr_en      = 1'b0;
    w_valid_nxt  = TDC_Ovalid;
    w_data_nxt   = TDC_Odata;
    w_int_nxt    = TDC_Oint;
    w_num_nxt    = TDC_Onum;
    w_last_nxt   = TDC_Olast;
    w_oovf_nxt   = TDC_Oovf;
    w_irq_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // TDC_INT is high only in the return cycle, where a new start is ignored
        if (w_start_rise && !TDC_INT) begin
          w_state_nxt  = S_ARMED;
          w_coarse_nxt = '0;
          w_count_nxt  = '0;
          w_ovf_nxt    = 1'b0;
        end
      end
      S_ARMED: begin
        w_coarse_nxt = r_coarse + COARSE_W'(1);
        w_wr_en      = w_store;
        w_count_nxt  = w_count_after;
        w_grace_nxt  = w_full;
        if (w_drop) w_ovf_nxt = 1'b1;
        if (w_close) begin
          if (w_count_after != '0) begin
            w_state_nxt = S_DRAIN;
            w_rd_nxt    = '0;
            w_valid_nxt = 1'b1;
            w_data_nxt  = (r_count == '0) ? w_hit_data : r_buf_data[0];
            w_int_nxt   = (r_count == '0) ? w_spad_cnt : r_buf_int[0];
            w_num_nxt   = w_count_after;
            w_last_nxt  = (w_count_after == NUM_W'(1));
            w_oovf_nxt  = r_ovf | w_drop;
          end else begin
            w_state_nxt = S_IDLE;
            w_irq_nxt   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (TDC_Ovalid && TDC_Oready) begin
          if (TDC_Olast) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_data_nxt  = '0;
            w_int_nxt   = '0;
            w_num_nxt   = '0;
            w_last_nxt  = 1'b0;
            w_oovf_nxt  = 1'b0;
            w_irq_nxt   = 1'b1;
          end else begin
            w_rd_nxt   = w_rd_inc;
            w_data_nxt = r_buf_data[IDX_W'(w_rd_inc)];
            w_int_nxt  = r_buf_int[IDX_W'(w_rd_inc)];
            w_last_nxt = (w_rd_inc == r_count - NUM_W'(1));
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_start_d  <= 1'b0;
      r_trig_d   <= 1'b0;
      r_coarse   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_grace    <= 1'b0;
      r_rd_idx   <= '0;
      TDC_Ovalid <= 1'b0;
      TDC_Odata  <= '0;
      TDC_Oint   <= '0;
      TDC_Onum   <= '0;
      TDC_Olast  <= 1'b0;
      TDC_Oovf   <= 1'b0;
      TDC_INT    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_start_d  <= TDC_start;
      r_trig_d   <= TDC_trigger;
      r_coarse   <= w_coarse_nxt;
      r_count    <= w_count_nxt;
      r_ovf      <= w_ovf_nxt;
      r_grace    <= w_grace_nxt;
      r_rd_idx   <= w_rd_nxt;
      TDC_Ovalid <= w_valid_nxt;
      TDC_Odata  <= w_data_nxt;
      TDC_Oint   <= w_int_nxt;
      TDC_Onum   <= w_num_nxt;
      TDC_Olast  <= w_last_nxt;
      TDC_Oovf   <= w_oovf_nxt;
      TDC_INT    <= w_irq_nxt;
    end
  end

  // Hit buffer, written in arrival order at the current hit count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_HITS; i++) begin
        r_buf_data[i] <= '0;
        r_buf_int[i]  <= '0;
      end
    end else if (w_wr_en) begin
      r_buf_data[IDX_W'(r_count)] <= w_hit_data;
      r_buf_int[IDX_W'(r_count)]  <= w_spad_cnt;
    end
  end

endmodule
